// File: rtl/uart_tx_arb.sv
//------------------------------------------------------------------------------
// uart_tx_arb : round-robin arbiter / write sequencer for a single-word flag
//               buffer, with optional per-requester locking and lock timeout.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int WORD_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_buf_set,
  output logic [WORD_WIDTH-1:0]         o_buf_din,
  input  logic                          i_buf_flag,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_locked,
  output logic                          o_lock_timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam bit C_TO_EN = (LOCK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] C_TO_VAL = CNT_W'(LOCK_TIMEOUT);
  localparam logic [ID_W-1:0]  C_LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  buf_set_q, buf_set_d;
  logic [WORD_WIDTH-1:0] buf_din_q, buf_din_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  lock_timeout_q, lock_timeout_d;

  logic                  can_issue;
  logic                  found;
  logic [ID_W-1:0]       pick;
  logic [ID_W-1:0]       cand;
  logic                  xfer;

  // The registered set strobe masks the cycle before the buffer flag rises.
  assign can_issue = ~i_buf_flag & ~buf_set_q;

  always_comb begin
    o_req_ready = '0;
    found       = 1'b0;
    pick        = last_grant_q;
    cand        = '0;
    if (state_q == ST_LOCKED) begin
      pick  = owner_q;
      found = i_req_valid[owner_q];
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
        if (!found && i_req_valid[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
    if (found && can_issue) begin
      o_req_ready[pick] = 1'b1;
    end
  end

  assign xfer = |o_req_ready;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    buf_set_d      = xfer;
    buf_din_d      = buf_din_q;
    grant_id_d     = grant_id_q;
    lock_timeout_d = 1'b0;

    if (xfer) begin
      buf_din_d    = i_req_data[int'(pick)*WORD_WIDTH +: WORD_WIDTH];
      grant_id_d   = pick;
      last_grant_d = pick;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer && i_req_lock[pick]) begin
          state_d = ST_LOCKED;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        // An owner transfer takes precedence over an expiry in the same cycle.
        if (xfer) begin
          cnt_d = '0;
          if (!i_req_lock[owner_q]) begin
            state_d = ST_IDLE;
          end
        end else if (C_TO_EN && (cnt_q == C_TO_VAL)) begin
          state_d        = ST_IDLE;
          lock_timeout_d = 1'b1;
          cnt_d          = '0;
        end else if (C_TO_EN && can_issue && !i_req_valid[owner_q]) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      last_grant_q   <= C_LAST_RST;
      cnt_q          <= '0;
      buf_set_q      <= 1'b0;
      buf_din_q      <= '0;
      grant_id_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      buf_set_q      <= buf_set_d;
      buf_din_q      <= buf_din_d;
      grant_id_q     <= grant_id_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign o_buf_set      = buf_set_q;
  assign o_buf_din      = buf_din_q;
  assign o_grant_id     = grant_id_q;
  assign o_locked       = (state_q == ST_LOCKED);
  assign o_lock_timeout = lock_timeout_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and write sequencer that lets `NUM_REQ` requesters share one UART single-word flag buffer. It grants one word at a time into the buffer and drives the buffer's set strobe and data input. It issues a new set only once the buffer flag has been cleared by the consumer, so the buffer's overflow error can never be raised through this path. Optional per-requester locking keeps multi-byte messages contiguous, with an idle timeout so a stalled owner cannot hold the buffer forever.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WORD_WIDTH`, 8: data word width; matches the buffer.
- `LOCK_TIMEOUT`, 255: idle cycles before a lock is forcibly released; 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `i_clk`  in  1  clock.
  - `i_rst`  in  1  synchronous, active-high reset.
- Requester side:
  - `i_req_valid`  in  NUM_REQ  per-requester word valid.
  - `i_req_lock`  in  NUM_REQ  per-requester lock request, sampled with the word; high means more words follow.
  - `i_req_data`  in  NUM_REQ*WORD_WIDTH  requester `i` data in bits `[i*WORD_WIDTH +: WORD_WIDTH]`.
  - `o_req_ready`  out  NUM_REQ  combinational, one-hot or zero; transfer occurs when valid & ready.
- Buffer side:
  - `o_buf_set`  out  1  registered one-cycle set strobe to the buffer.
  - `o_buf_din`  out  WORD_WIDTH  registered data, valid while `o_buf_set` is high.
  - `i_buf_flag`  in  1  buffer full flag.
- Status:
  - `o_grant_id`  out  $clog2(NUM_REQ)  index of the requester whose word is on `o_buf_din`.
  - `o_locked`  out  1  high while in LOCKED.
  - `o_lock_timeout`  out  1  one-cycle pulse when a lock is force-released.

## Operation
- `can_issue = ~i_buf_flag & ~o_buf_set`. Masking with `o_buf_set` covers the cycle before the buffer flag rises.
- States:
  - IDLE: any requester may be granted.
  - LOCKED: only `owner` may be granted.
- Arbitration in IDLE:
  - Search starts at `(last_grant+1) mod NUM_REQ` and proceeds upward with wrap.
  - The first index with valid high gets ready, gated by `can_issue`.
  - `last_grant` updates only on a transfer.
- Arbitration in LOCKED: `o_req_ready[owner] = can_issue & i_req_valid[owner]`; every other ready bit is 0.
- On a transfer from requester `k`:
  - Next cycle: `o_buf_set=1`, `o_buf_din=data[k]`, `o_grant_id=k`.
  - `last_grant=k`.
- Lock transitions:
  - IDLE→LOCKED: on a transfer with `i_req_lock[k]=1`; `owner=k`.
  - LOCKED→IDLE: on an owner transfer with lock=0 (last word). That word is still issued.
  - LOCKED→IDLE: on timeout.
- Timeout counter:
  - Width `$clog2(LOCK_TIMEOUT+1)`.
  - Cleared on entry to LOCKED and on each owner transfer.
  - Increments each LOCKED cycle with `can_issue & ~i_req_valid[owner]`.
  - Holds while the buffer is busy.
  - Reaching `LOCK_TIMEOUT`: next cycle state=IDLE, `o_lock_timeout=1` for one cycle, counter cleared. `last_grant` is unchanged, so round-robin resumes after the stalled owner.
  - Never increments when `LOCK_TIMEOUT=0`.
- `i_req_data` of non-granted requesters is ignored.
- Deasserting valid without a transfer is allowed; nothing is issued.

## Timing
- Reset values, one cycle after `i_rst` is sampled high:
  - `o_buf_set=0`, `o_buf_din=0`, `o_grant_id=0`, `o_locked=0`, `o_lock_timeout=0`.
  - state=IDLE, `last_grant=NUM_REQ-1` (requester 0 has first priority), counter=0.
- Reset mid-operation: any pending set is dropped; no set is issued in the cycle after reset. Buffer contents are the buffer's concern.
- Latency: transfer in cycle T → `o_buf_set` in T+1 → flag high in T+2. No transfer is possible in T+1 or while the flag is high.
- Throughput: at most one word per buffer clear. Earliest next transfer is in the cycle the flag is sampled low.
- Simultaneous events:
  - A flag clear and a request in the same cycle: the transfer happens in that cycle.
  - An owner word with lock=0 in the same cycle the timeout is reached: the transfer wins. `o_lock_timeout` stays 0 and state goes to IDLE.
- `o_req_ready` is a combinational function of the registered state, `i_req_valid` and `i_buf_flag`. There is no path from `i_req_data` or `i_req_lock`.

## Test plan
- **Round-robin**: NUM_REQ=4, all valid continuously, buffer cleared 3 cycles after each set → grant order 0,1,2,3,0,1. `o_buf_din` matches each requester's data. The buffer overflow error never asserts.
- **Issue gating**: flag held high 20 cycles with req0 valid → no ready and no set. Clear flag in cycle C → ready0 in C, `o_buf_set` in C+1, no second set before the flag falls again.
- **Lock**: req1 sends 0xA1 (lock=1), 0xA2 (lock=1), 0xA3 (lock=0) while req0/2/3 are valid → the three words are contiguous with `o_grant_id=1`. `o_locked` falls after 0xA3. Next grant is 2.
- **Timeout**: LOCK_TIMEOUT=8, req2 locks then drops valid, flag clear → `o_lock_timeout` pulses 8 idle cycles later. Next grant is 3; req0 is granted if 3 is idle.
- **Reset mid-operation**: assert `i_rst` in the transfer cycle T → `o_buf_set=0` at T+1, all outputs at reset values. First grant after reset is requester 0.
- **Timeout race**: LOCK_TIMEOUT=4, owner presents a lock=0 word in the expiry cycle → the word is issued, no timeout pulse, state is IDLE.
